// File: rtl/zom_motion_ctrl.sv
// zom_motion_ctrl
// ---------------
// Lane controller for a single zombie, clocked by the frame clock. The zombie
// spawns at (startX, startY) and walks left one STEP every STEP_DIV frames.
// While a plant blocks it, it stops and bites every EAT_PERIOD frames. Damage
// strobes reduce its hit points. A lethal hit starts a DIE_FRAMES death
// timer, after which the zombie parks off-screen. If it reaches HOUSE_X it
// stops there and raises the sticky END flag.
//
// Optional feature: macro ZOM_SLOW_EN adds a `slow` input. A pulse on it
// arms a 300-frame slow timer. While the timer runs, the step period and the
// bite period are both doubled.
//
// Ports:
//   frame_clk   in   frame clock; all state changes on its rising edge
//   Reset_n     in   asynchronous active-low reset
//   spawn       in   spawn request, sampled only in IDLE
//   startX/Y    in   spawn coordinates (Y selects the lane)
//   block_valid in   a plant occupies blockX in this lane
//   blockX      in   right edge of the blocking plant
//   hit/damage  in   one-frame damage strobe and its amount
//   slow        in   (ZOM_SLOW_EN only) slow-effect pulse
//   ZomX/ZomY   out  current position
//   hp          out  current hit points
//   state_o     out  0=IDLE 1=WALK 2=EAT 3=DYING 4=REACHED
//   alive       out  high in WALK and EAT
//   eat         out  one-frame bite pulse
//   END         out  sticky: zombie reached the house
module zom_motion_ctrl #(
  parameter int unsigned X_W        = 10,
  parameter int unsigned STEP       = 1,
  parameter int unsigned STEP_DIV   = 2,
  parameter int unsigned HP_W       = 8,
  parameter int unsigned MAX_HP     = 100,
  parameter int unsigned EAT_PERIOD = 30,
  parameter int unsigned DIE_FRAMES = 60,
  parameter int unsigned HOUSE_X    = 0,
  parameter int unsigned PARK_X     = 680
) (
  input  logic            frame_clk,
  input  logic            Reset_n,
  input  logic            spawn,
  input  logic [X_W-1:0]  startX,
  input  logic [X_W-1:0]  startY,
  input  logic            block_valid,
  input  logic [X_W-1:0]  blockX,
  input  logic            hit,
  input  logic [HP_W-1:0] damage,
`ifdef ZOM_SLOW_EN
  input  logic            slow,
`endif
  output logic [X_W-1:0]  ZomX,
  output logic [X_W-1:0]  ZomY,
  output logic [HP_W-1:0] hp,
  output logic [2:0]      state_o,
  output logic            alive,
  output logic            eat,
  output logic            END
);

  // 9 bits holds the doubled periods (up to 2*255-1) used by the slow feature.
  localparam int unsigned CNT_W = 9;
  localparam logic [X_W:0] HOUSE_LIM = (X_W+1)'(HOUSE_X + STEP);
  localparam logic [X_W:0] ONE_W     = (X_W+1)'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WALK    = 3'd1,
    ST_EAT     = 3'd2,
    ST_DYING   = 3'd3,
    ST_REACHED = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [X_W-1:0]    zom_x_q, zom_x_d;
  logic [X_W-1:0]    zom_y_q, zom_y_d;
  logic [HP_W-1:0]   hp_q, hp_d;
  logic              eat_q, eat_d;
  logic              end_q, end_d;
  logic [CNT_W-1:0]  step_cnt_q, step_cnt_d;
  logic [CNT_W-1:0]  eat_cnt_q, eat_cnt_d;
  logic [7:0]        die_cnt_q, die_cnt_d;

  logic              step_last;
  logic              eat_last;
  logic              kill;
  logic [HP_W-1:0]   hp_after;
  logic              block_hit;
  logic              at_house;

`ifdef ZOM_SLOW_EN
  logic [8:0]        slow_timer_q, slow_timer_d;
  logic              slowed;

  assign slowed = (slow_timer_q != 9'd0);
  // ">=" rather than "==" so a counter already past the short limit, when the
  // timer expires mid-period, still fires instead of wrapping around.
  assign step_last = step_cnt_q >= (slowed ? CNT_W'(2*STEP_DIV - 1) : CNT_W'(STEP_DIV - 1));
  assign eat_last  = eat_cnt_q  >= (slowed ? CNT_W'(2*EAT_PERIOD - 1) : CNT_W'(EAT_PERIOD - 1));

  always_comb begin
    slow_timer_d = 9'd0;
    if (state_q == ST_WALK || state_q == ST_EAT) begin
      if (slow)
        slow_timer_d = 9'd300;
      else if (slowed)
        slow_timer_d = slow_timer_q - 9'd1;
    end
  end
`else
  assign step_last = (step_cnt_q >= CNT_W'(STEP_DIV - 1));
  assign eat_last  = (eat_cnt_q  >= CNT_W'(EAT_PERIOD - 1));
`endif

  assign kill     = hit && (damage >= hp_q);
  assign hp_after = hit ? (hp_q - damage) : hp_q;
  // Compare one bit wider so blockX+1 at the top of the range cannot wrap.
  assign block_hit = block_valid && ({1'b0, zom_x_q} <= ({1'b0, blockX} + ONE_W));
  // Clamp at the house instead of stepping below it.
  assign at_house  = ({1'b0, zom_x_q} <= HOUSE_LIM);

  always_comb begin
    state_d    = state_q;
    zom_x_d    = zom_x_q;
    zom_y_d    = zom_y_q;
    hp_d       = hp_q;
    eat_d      = 1'b0;
    end_d      = end_q;
    step_cnt_d = step_cnt_q;
    eat_cnt_d  = eat_cnt_q;
    die_cnt_d  = die_cnt_q;

    case (state_q)
      ST_IDLE: begin
        zom_x_d = X_W'(PARK_X);
        if (spawn) begin
          state_d    = ST_WALK;
          zom_x_d    = startX;
          zom_y_d    = startY;
          hp_d       = HP_W'(MAX_HP);
          step_cnt_d = '0;
        end
      end

      ST_WALK: begin
        if (kill) begin
          hp_d      = '0;
          state_d   = ST_DYING;
          die_cnt_d = '0;
        end else begin
          hp_d = hp_after;
          if (block_hit) begin
            state_d   = ST_EAT;
            eat_cnt_d = '0;
          end else if (step_last) begin
            step_cnt_d = '0;
            if (at_house) begin
              zom_x_d = X_W'(HOUSE_X);
              state_d = ST_REACHED;
              end_d   = 1'b1;
            end else begin
              zom_x_d = zom_x_q - X_W'(STEP);
            end
          end else begin
            step_cnt_d = step_cnt_q + CNT_W'(1);
          end
        end
      end

      ST_EAT: begin
        if (kill) begin
          hp_d      = '0;
          state_d   = ST_DYING;
          die_cnt_d = '0;
        end else begin
          hp_d = hp_after;
          if (!block_valid) begin
            state_d    = ST_WALK;
            step_cnt_d = '0;
            eat_cnt_d  = '0;
          end else if (eat_last) begin
            eat_d     = 1'b1;
            eat_cnt_d = '0;
          end else begin
            eat_cnt_d = eat_cnt_q + CNT_W'(1);
          end
        end
      end

      ST_DYING: begin
        if (die_cnt_q == 8'(DIE_FRAMES - 1)) begin
          state_d = ST_IDLE;
          zom_x_d = X_W'(PARK_X);
        end else begin
          die_cnt_d = die_cnt_q + 8'd1;
        end
      end

      ST_REACHED: begin
        zom_x_d = X_W'(HOUSE_X);
        end_d   = 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= ST_IDLE;
      zom_x_q      <= X_W'(PARK_X);
      zom_y_q      <= '0;
      hp_q         <= '0;
      eat_q        <= 1'b0;
      end_q        <= 1'b0;
      step_cnt_q   <= '0;
      eat_cnt_q    <= '0;
      die_cnt_q    <= '0;
`ifdef ZOM_SLOW_EN
      slow_timer_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      zom_x_q      <= zom_x_d;
      zom_y_q      <= zom_y_d;
      hp_q         <= hp_d;
      eat_q        <= eat_d;
      end_q        <= end_d;
      step_cnt_q   <= step_cnt_d;
      eat_cnt_q    <= eat_cnt_d;
      die_cnt_q    <= die_cnt_d;
`ifdef ZOM_SLOW_EN
      slow_timer_q <= slow_timer_d;
`endif
    end
  end

  assign ZomX    = zom_x_q;
  assign ZomY    = zom_y_q;
  assign hp      = hp_q;
  assign eat     = eat_q;
  assign END     = end_q;
  assign state_o = state_q;
  assign alive   = (state_q == ST_WALK) || (state_q == ST_EAT);

endmodule

// File: tb/tb_zom_motion_ctrl.sv
// Directed bench for zom_motion_ctrl. Two instances share all inputs: u_dut
// uses the default parameters, u_dut2 uses STEP=2 for the house-clamp case.
// Inputs change and outputs are sampled on the falling edge of frame_clk.
module tb_zom_motion_ctrl;

  logic        frame_clk;
  logic        Reset_n;
  logic        spawn;
  logic [9:0]  startX, startY, blockX;
  logic        block_valid, hit;
  logic [7:0]  damage;
`ifdef ZOM_SLOW_EN
  logic        slow;
`endif

  logic [9:0]  zom_x, zom_y, zom_x2, zom_y2;
  logic [7:0]  hp, hp2;
  logic [2:0]  state, state2;
  logic        alive, alive2, eat, eat2, end_o, end2;

  int n_checks = 0;
  int n_fail   = 0;

  zom_motion_ctrl u_dut (
    .frame_clk(frame_clk), .Reset_n(Reset_n), .spawn(spawn),
    .startX(startX), .startY(startY), .block_valid(block_valid),
    .blockX(blockX), .hit(hit), .damage(damage),
`ifdef ZOM_SLOW_EN
    .slow(slow),
`endif
    .ZomX(zom_x), .ZomY(zom_y), .hp(hp), .state_o(state),
    .alive(alive), .eat(eat), .END(end_o)
  );

  zom_motion_ctrl #(.STEP(2)) u_dut2 (
    .frame_clk(frame_clk), .Reset_n(Reset_n), .spawn(spawn),
    .startX(startX), .startY(startY), .block_valid(block_valid),
    .blockX(blockX), .hit(hit), .damage(damage),
`ifdef ZOM_SLOW_EN
    .slow(slow),
`endif
    .ZomX(zom_x2), .ZomY(zom_y2), .hp(hp2), .state_o(state2),
    .alive(alive2), .eat(eat2), .END(end2)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge frame_clk);
  endtask

  task automatic do_reset();
    Reset_n     = 1'b0;
    spawn       = 1'b0;
    hit         = 1'b0;
    damage      = '0;
    block_valid = 1'b0;
    blockX      = '0;
    startX      = '0;
    startY      = '0;
`ifdef ZOM_SLOW_EN
    slow        = 1'b0;
`endif
    tick(2);
    Reset_n = 1'b1;
  endtask

  task automatic spawn_zom(input logic [9:0] x, input logic [9:0] y);
    startX = x;
    startY = y;
    spawn  = 1'b1;
    tick(1);
    spawn  = 1'b0;
  endtask

  task automatic hit_once(input logic [7:0] d);
    damage = d;
    hit    = 1'b1;
    tick(1);
    hit    = 1'b0;
  endtask

  initial begin
    // Reset values
    Reset_n = 1'b0;
    spawn = 1'b0; hit = 1'b0; damage = '0; block_valid = 1'b0;
    blockX = '0; startX = '0; startY = '0;
`ifdef ZOM_SLOW_EN
    slow = 1'b0;
`endif
    tick(2);
    check("rst_state", 32'(state), 0);
    check("rst_x", 32'(zom_x), 680);
    check("rst_y", 32'(zom_y), 0);
    check("rst_hp", 32'(hp), 0);
    check("rst_eat", 32'(eat), 0);
    check("rst_end", 32'(end_o), 0);
    check("rst_alive", 32'(alive), 0);
    Reset_n = 1'b1;
    tick(1);

    // Spawn and walk
    spawn_zom(10'd200, 10'd96);
    check("spawn_state", 32'(state), 1);
    check("spawn_x", 32'(zom_x), 200);
    check("spawn_y", 32'(zom_y), 96);
    check("spawn_hp", 32'(hp), 100);
    check("spawn_alive", 32'(alive), 1);
    tick(2);
    check("walk_x2", 32'(zom_x), 199);
    tick(18);
    check("walk_x20", 32'(zom_x), 190);

    // Damage and death
    hit_once(8'd40);
    check("hit1_hp", 32'(hp), 60);
    hit_once(8'd40);
    check("hit2_hp", 32'(hp), 20);
    check("hit2_x", 32'(zom_x), 189);
    hit_once(8'd40);
    check("kill_state", 32'(state), 3);
    check("kill_hp", 32'(hp), 0);
    check("kill_x", 32'(zom_x), 189);
    check("kill_alive", 32'(alive), 0);
    tick(59);
    check("dying59_state", 32'(state), 3);
    check("dying59_x", 32'(zom_x), 189);
    tick(1);
    check("dead_state", 32'(state), 0);
    check("dead_x", 32'(zom_x), 680);
    check("dead_alive", 32'(alive), 0);

    // Blocked and biting
    blockX = 10'd100;
    block_valid = 1'b1;
    spawn_zom(10'd120, 10'd64);
    tick(38);
    check("approach_x", 32'(zom_x), 101);
    check("approach_state", 32'(state), 1);
    tick(1);
    check("eat_enter_state", 32'(state), 2);
    check("eat_enter_pulse", 32'(eat), 0);
    tick(29);
    check("eat29", 32'(eat), 0);
    tick(1);
    check("eat30", 32'(eat), 1);
    tick(1);
    check("eat31", 32'(eat), 0);
    check("eat_hold_x", 32'(zom_x), 101);
    tick(28);
    check("eat59", 32'(eat), 0);
    tick(1);
    check("eat60", 32'(eat), 1);
    tick(1);
    check("eat61", 32'(eat), 0);
    block_valid = 1'b0;
    tick(1);
    check("unblock_state", 32'(state), 1);
    check("unblock_eat", 32'(eat), 0);
    tick(1);
    check("unblock_x1", 32'(zom_x), 101);
    tick(1);
    check("unblock_x2", 32'(zom_x), 100);

    // Non-lethal hit does not stop a step; exact-hp hit kills on a step frame
    do_reset();
    spawn_zom(10'd50, 10'd32);
    tick(1);
    hit_once(8'd99);
    check("hitstep_hp", 32'(hp), 1);
    check("hitstep_x", 32'(zom_x), 49);
    check("hitstep_state", 32'(state), 1);
    tick(1);
    hit_once(8'd1);
    check("killstep_state", 32'(state), 3);
    check("killstep_x", 32'(zom_x), 49);
    check("killstep_hp", 32'(hp), 0);

    // Lethal hit on the block-entry frame
    do_reset();
    blockX = 10'd100;
    block_valid = 1'b1;
    spawn_zom(10'd101, 10'd32);
    hit_once(8'd200);
    check("killblock_state", 32'(state), 3);
    check("killblock_x", 32'(zom_x), 101);
    check("killblock_eat", 32'(eat), 0);

    // blockX at the top of the range must not wrap
    do_reset();
    blockX = 10'd1023;
    block_valid = 1'b1;
    spawn_zom(10'd500, 10'd0);
    tick(1);
    check("wrap_state", 32'(state), 2);
    check("wrap_x", 32'(zom_x), 500);

    // Asynchronous reset in the middle of a bite
    do_reset();
    blockX = 10'd100;
    block_valid = 1'b1;
    spawn_zom(10'd101, 10'd32);
    tick(1);
    tick(30);
    check("prerst_eat", 32'(eat), 1);
    #2;
    Reset_n = 1'b0;
    #1;
    check("arst_state", 32'(state), 0);
    check("arst_x", 32'(zom_x), 680);
    check("arst_eat", 32'(eat), 0);
    check("arst_hp", 32'(hp), 0);
    check("arst_alive", 32'(alive), 0);
    @(negedge frame_clk);
    Reset_n = 1'b1;
    tick(3);
    check("noresume_state", 32'(state), 0);
    check("noresume_x", 32'(zom_x), 680);

    // Reach the house (u_dut2 STEP=2, u_dut STEP=1)
    do_reset();
    spawn_zom(10'd3, 10'd16);
    tick(2);
    check("house2_x1", 32'(zom_x2), 1);
    check("house2_walk", 32'(state2), 1);
    tick(2);
    check("house2_x0", 32'(zom_x2), 0);
    check("house2_state", 32'(state2), 4);
    check("house2_end", 32'(end2), 1);
    check("house1_notyet_end", 32'(end_o), 0);
    check("house1_x1", 32'(zom_x), 1);
    tick(2);
    check("house1_x0", 32'(zom_x), 0);
    check("house1_state", 32'(state), 4);
    check("house1_end", 32'(end_o), 1);
    damage = 8'd200;
    hit = 1'b1;
    spawn = 1'b1;
    startX = 10'd300;
    tick(3);
    hit = 1'b0;
    spawn = 1'b0;
    check("reached_state", 32'(state2), 4);
    check("reached_end", 32'(end2), 1);
    check("reached_hp", 32'(hp2), 100);
    check("reached_x", 32'(zom_x2), 0);
    check("reached1_end", 32'(end_o), 1);

`ifdef ZOM_SLOW_EN
    // Slow effect: step every 4 frames for the timer's life, then every 2
    do_reset();
    spawn_zom(10'd500, 10'd0);
    tick(2);
    check("slow_x_e2", 32'(zom_x), 499);
    slow = 1'b1;
    tick(1);
    slow = 1'b0;
    tick(3);
    check("slow_x_e6", 32'(zom_x), 498);
    tick(3);
    check("slow_x_e9", 32'(zom_x), 498);
    tick(1);
    check("slow_x_e10", 32'(zom_x), 497);
    tick(292);
    check("slow_x_e302", 32'(zom_x), 424);
    tick(2);
    check("slow_x_e304", 32'(zom_x), 423);
    tick(2);
    check("slow_x_e306", 32'(zom_x), 422);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
